// File: rtl/mem_responder.sv
// Word-organised memory responder for the CPU imem/dmem port with fixed LATENCY.
// Latency: request accepted at E0, mem_resp high in the cycle after E0+(LATENCY-1); no backpressure, busy requests wait in IDLE.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_rmask,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [AW-1:0]   op_idx_q;
    logic [3:0]      op_wmask_q;
    logic [31:0]     op_wdata_q;
    logic            op_is_wr_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            req;
    logic            enter_resp;
    logic [AW-1:0]   req_idx;
    logic [AW-1:0]   ld_idx;
    logic [AW-1:0]   cur_idx;
    logic [3:0]      cur_wmask;
    logic [31:0]     cur_wdata;
    logic            cur_is_wr;
    logic            unused_bits;

    assign req_idx     = mem_addr[AW+1:2];
    assign ld_idx      = ld_addr[AW+1:2];
    assign unused_bits = &{1'b0, mem_addr[31:AW+2], mem_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};

    // With LATENCY=1 the commit edge is the acceptance edge, so the live inputs are the op.
    always_comb begin
        req        = (|mem_rmask) | (|mem_wmask);
        cur_idx    = op_idx_q;
        cur_wmask  = op_wmask_q;
        cur_wdata  = op_wdata_q;
        cur_is_wr  = op_is_wr_q;
        if (state == IDLE) begin
            cur_idx   = req_idx;
            cur_wmask = mem_wmask;
            cur_wdata = mem_wdata;
            cur_is_wr = |mem_wmask;
        end
        enter_resp = ((state == IDLE) && req && (LATENCY == 1)) ||
                     ((state == BUSY) && (cnt == 4'd0));
    end

    // Functional lanes are written after the backdoor word so they win on collision.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_idx] <= ld_wdata;
        end
        if (enter_resp && rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wmask[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op_idx_q   <= '0;
            op_wmask_q <= 4'd0;
            op_wdata_q <= 32'd0;
            op_is_wr_q <= 1'b0;
            mem_rdata  <= 32'd0;
            mem_resp   <= 1'b0;
            proto_err  <= 1'b0;
            rd_count   <= 32'd0;
            wr_count   <= 32'd0;
        end else begin
            mem_resp  <= 1'b0;
            proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_idx_q   <= req_idx;
                        op_wmask_q <= mem_wmask;
                        op_wdata_q <= mem_wdata;
                        op_is_wr_q <= |mem_wmask;
                        proto_err  <= (|mem_rmask) & (|mem_wmask);
                        if (LATENCY == 1) begin
                            state    <= RESP;
                            mem_resp <= 1'b1;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state    <= RESP;
                        mem_resp <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (op_is_wr_q) begin
                        if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
                    end else begin
                        if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (enter_resp && !cur_is_wr) begin
                mem_rdata <= mem[cur_idx];
            end
        end
    end

endmodule
